// File: rtl/matmul_mem.sv
// Single-port data memory for the matmul engine with a lower-priority host port.
// Engine always wins; host is served on engine-idle cycles via req/gnt.
module matmul_mem #(
  parameter int unsigned MEM_AW   = 16,
  parameter int unsigned MEM_DW   = 32,
  parameter int unsigned DEPTH    = 4096,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              e_req,
  input  logic              e_write,
  input  logic [MEM_AW-1:0] e_addr,
  input  logic [MEM_DW-1:0] e_wdata,
  output logic              e_rdata_vld,
  output logic [MEM_DW-1:0] e_rdata,
  input  logic              h_req,
  input  logic              h_write,
  input  logic [MEM_AW-1:0] h_addr,
  input  logic [MEM_DW-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rdata_vld,
  output logic [MEM_DW-1:0] h_rdata,
  output logic              h_starve,
  output logic              err_oor,
  input  logic              err_clr
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [MEM_DW-1:0] mem [DEPTH];

  logic              acc_en;
  logic              acc_write;
  logic [MEM_AW-1:0] acc_addr;
  logic [MEM_DW-1:0] acc_wdata;
  logic              acc_oor;
  logic [MEM_DW-1:0] rdata_c;

  logic              e_rdata_vld_q, e_rdata_vld_d;
  logic [MEM_DW-1:0] e_rdata_q, e_rdata_d;
  logic              h_rdata_vld_q, h_rdata_vld_d;
  logic [MEM_DW-1:0] h_rdata_q, h_rdata_d;
  logic              err_oor_q, err_oor_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              h_starve_q, h_starve_d;

  // Arbitration and the shared array port; reset blocks any access
  always_comb begin
    h_gnt     = h_req & ~e_req & rst_n;
    acc_en    = (e_req & rst_n) | h_gnt;
    acc_write = e_req ? e_write : h_write;
    acc_addr  = e_req ? e_addr  : h_addr;
    acc_wdata = e_req ? e_wdata : h_wdata;
    acc_oor   = 32'(acc_addr) >= DEPTH;
    rdata_c   = acc_oor ? '0 : mem[acc_addr[IDX_W-1:0]];
  end

  // Next-state for read returns, error flag and starvation tracking
  always_comb begin
    e_rdata_vld_d = e_req & ~e_write;
    e_rdata_d     = e_rdata_q;
    h_rdata_vld_d = h_gnt & ~h_write;
    h_rdata_d     = h_rdata_q;
    err_oor_d     = err_oor_q;
    wcnt_d        = '0;

    if (e_rdata_vld_d) e_rdata_d = rdata_c;
    if (h_rdata_vld_d) h_rdata_d = rdata_c;

    if (err_clr) err_oor_d = 1'b0;
    if (acc_en && acc_oor) err_oor_d = 1'b1;

    if (h_req && !h_gnt) begin
      wcnt_d = (wcnt_q == CNT_W'(MAX_WAIT)) ? wcnt_q : wcnt_q + CNT_W'(1);
    end
    h_starve_d = (wcnt_d == CNT_W'(MAX_WAIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_rdata_vld_q <= 1'b0;
      e_rdata_q     <= '0;
      h_rdata_vld_q <= 1'b0;
      h_rdata_q     <= '0;
      err_oor_q     <= 1'b0;
      wcnt_q        <= '0;
      h_starve_q    <= 1'b0;
    end else begin
      e_rdata_vld_q <= e_rdata_vld_d;
      e_rdata_q     <= e_rdata_d;
      h_rdata_vld_q <= h_rdata_vld_d;
      h_rdata_q     <= h_rdata_d;
      err_oor_q     <= err_oor_d;
      wcnt_q        <= wcnt_d;
      h_starve_q    <= h_starve_d;
    end
  end

  // Array has no reset; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (acc_en && acc_write && !acc_oor) mem[acc_addr[IDX_W-1:0]] <= acc_wdata;
  end

  assign e_rdata_vld = e_rdata_vld_q;
  assign e_rdata     = e_rdata_q;
  assign h_rdata_vld = h_rdata_vld_q;
  assign h_rdata     = h_rdata_q;
  assign err_oor     = err_oor_q;
  assign h_starve    = h_starve_q;

endmodule

// File: tb/tb_matmul_mem.sv
// Directed bench for matmul_mem: read returns checked by a queue-based scoreboard,
// control outputs (gnt, starve, err, reset) checked inline.
module tb_matmul_mem;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          e_req, e_write;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          e_rdata_vld;
  logic [DW-1:0] e_rdata;
  logic          h_req, h_write;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt, h_rdata_vld;
  logic [DW-1:0] h_rdata;
  logic          h_starve, err_oor, err_clr;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t e_q[$];
  exp_t h_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  matmul_mem #(.MEM_AW(AW), .MEM_DW(DW), .DEPTH(4096), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .e_req(e_req), .e_write(e_write), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_rdata_vld(e_rdata_vld), .e_rdata(e_rdata),
    .h_req(h_req), .h_write(h_write), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rdata_vld(h_rdata_vld), .h_rdata(h_rdata),
    .h_starve(h_starve), .err_oor(err_oor), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_e(input logic [DW-1:0] d);
    e_q.push_back('{data: d, due: cyc + 1});
  endtask

  task automatic push_h(input logic [DW-1:0] d);
    h_q.push_back('{data: d, due: cyc + 1});
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    h_req = 1'b1; h_write = 1'b1; h_addr = a; h_wdata = d;
    @(negedge clk);
    chk("host_wr_gnt", DW'(h_gnt), 32'd1);
    step();
    h_req = 1'b0;
  endtask

  task automatic host_rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
    h_req = 1'b1; h_write = 1'b0; h_addr = a;
    @(negedge clk);
    chk("host_rd_gnt", DW'(h_gnt), 32'd1);
    push_h(d);
    step();
    h_req = 1'b0;
  endtask

  task automatic eng(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    e_req = 1'b1; e_write = w; e_addr = a; e_wdata = d;
    if (!w) push_e(d);
    step();
    e_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; err_clr = 1'b0;
    e_req = 1'b0; e_write = 1'b0; e_addr = '0; e_wdata = '0;
    h_req = 1'b0; h_write = 1'b0; h_addr = '0; h_wdata = '0;

    // Scoreboard monitor: pops on every valid return and checks data and latency
    fork
      forever begin
        exp_t x;
        @(negedge clk);
        if (e_rdata_vld) begin
          if (e_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL e_unexpected: got vld=1 data 0x%08h expected no read", e_rdata);
          end else begin
            x = e_q.pop_front();
            chk("e_rdata", e_rdata, x.data);
            chk("e_latency", DW'(cyc), DW'(x.due));
          end
        end
        if (h_rdata_vld) begin
          if (h_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL h_unexpected: got vld=1 data 0x%08h expected no read", h_rdata);
          end else begin
            x = h_q.pop_front();
            chk("h_rdata", h_rdata, x.data);
            chk("h_latency", DW'(cyc), DW'(x.due));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_e_vld", DW'(e_rdata_vld), 32'd0);
    chk("rst_h_vld", DW'(h_rdata_vld), 32'd0);
    chk("rst_err", DW'(err_oor), 32'd0);
    chk("rst_starve", DW'(h_starve), 32'd0);
    chk("rst_e_rdata", e_rdata, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Host write then read back
    host_wr(16'd5, 32'hDEAD_BEEF);
    host_rd(16'd5, 32'hDEAD_BEEF);

    // Preload and engine burst while host waits
    host_wr(16'd0, 32'd10);
    host_wr(16'd1, 32'd20);
    host_wr(16'd2, 32'd30);
    h_req = 1'b1; h_write = 1'b0; h_addr = 16'd1;
    for (int i = 0; i < 3; i++) begin
      e_req = 1'b1; e_write = 1'b0; e_addr = AW'(i);
      push_e(DW'(10 * (i + 1)));
      @(negedge clk);
      chk("burst_gnt_low", DW'(h_gnt), 32'd0);
      step();
    end
    e_req = 1'b0;
    @(negedge clk);
    chk("burst_gnt_after", DW'(h_gnt), 32'd1);
    push_h(32'd20);
    step();
    h_req = 1'b0;

    // Write visibility on both ports
    eng(1'b1, 16'd9, 32'h7);
    eng(1'b0, 16'd9, 32'h7);
    host_rd(16'd9, 32'h7);

    // Engine write beats a pending host read to the same address
    h_req = 1'b1; h_write = 1'b0; h_addr = 16'd9;
    e_req = 1'b1; e_write = 1'b1; e_addr = 16'd9; e_wdata = 32'h55;
    @(negedge clk);
    chk("coll_gnt_low", DW'(h_gnt), 32'd0);
    step();
    e_req = 1'b0;
    @(negedge clk);
    chk("coll_gnt", DW'(h_gnt), 32'd1);
    push_h(32'h55);
    step();
    h_req = 1'b0;

    // Out-of-range accesses and sticky error
    host_wr(16'h1000, 32'hCAFE_0000);
    @(negedge clk);
    chk("oor_set", DW'(err_oor), 32'd1);
    step();
    host_rd(16'h1000, 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    chk("oor_clr", DW'(err_oor), 32'd0);
    step();
    err_clr = 1'b1;
    eng(1'b0, 16'h1000, 32'd0);
    err_clr = 1'b0;
    @(negedge clk);
    chk("oor_set_wins", DW'(err_oor), 32'd1);
    step();
    host_rd(16'd0, 32'd10);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    host_wr(16'd4095, 32'h0F0F_0F0F);
    host_rd(16'd4095, 32'h0F0F_0F0F);
    @(negedge clk);
    chk("top_addr_no_err", DW'(err_oor), 32'd0);
    step();

    // Starvation with MAX_WAIT=4
    h_req = 1'b1; h_write = 1'b0; h_addr = 16'd5;
    for (int i = 0; i < 6; i++) begin
      e_req = 1'b1; e_write = 1'b0; e_addr = 16'd0;
      push_e(32'd10);
      @(negedge clk);
      chk("starve_gnt_low", DW'(h_gnt), 32'd0);
      chk("starve_level", DW'(h_starve), (i >= 4) ? 32'd1 : 32'd0);
      step();
    end
    e_req = 1'b0;
    @(negedge clk);
    chk("starve_gnt", DW'(h_gnt), 32'd1);
    chk("starve_held", DW'(h_starve), 32'd1);
    push_h(32'hDEAD_BEEF);
    step();
    h_req = 1'b0;
    @(negedge clk);
    chk("starve_clear", DW'(h_starve), 32'd0);
    step();

    // Reset in the cycle after an engine read; the read's valid is dropped
    err_clr = 1'b0;
    host_wr(16'h2000, 32'h1);
    e_req = 1'b1; e_write = 1'b0; e_addr = 16'd9;
    step();
    rst_n = 1'b0; e_req = 1'b0; h_req = 1'b1; h_write = 1'b0; h_addr = 16'd9;
    #1;
    chk("mid_rst_e_vld", DW'(e_rdata_vld), 32'd0);
    chk("mid_rst_h_vld", DW'(h_rdata_vld), 32'd0);
    chk("mid_rst_gnt", DW'(h_gnt), 32'd0);
    chk("mid_rst_err", DW'(err_oor), 32'd0);
    chk("mid_rst_starve", DW'(h_starve), 32'd0);
    h_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    host_rd(16'd9, 32'h55);
    eng(1'b0, 16'd5, 32'hDEAD_BEEF);

    repeat (3) step();
    chk("e_queue_empty", DW'(e_q.size()), 32'd0);
    chk("h_queue_empty", DW'(h_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
